// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined multi-mode barrel shifter with valid/ready handshakes on both sides.
//   Ops: 000 ROR, 001 ROL, 010 SRL, 011 SRA, 100 SLL, 101..111 pass-through.
//   N registered stages; stage k shifts/rotates right by 2**k when amt[k] is set.
//   Left ops bit-reverse the operand before stage 0 and the result of the last stage.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data [2**N]        operand
//   in_amt  [N]           shift/rotate amount
//   in_op   [3]           operation code
//   out_valid/out_ready   output handshake
//   out_data [2**N]       result
//   out_zero              registered (out_data == 0)
//   out_sticky            OR of discarded bits (0 unless BARREL_SHIFTER_STICKY_EN)
//
// Build option: define BARREL_SHIFTER_STICKY_EN to synthesise sticky tracking.
module barrel_shifter_pipe #(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2**N-1:0]  in_data,
  input  logic [N-1:0]     in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2**N-1:0]  out_data,
  output logic             out_zero,
  output logic             out_sticky
);

  localparam int W = 2**N;

  typedef enum logic [2:0] {
    OP_ROR = 3'b000,
    OP_ROL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_SLL = 3'b100
  } op_e;

  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  function automatic logic is_rot(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

  function automatic logic is_pass(input logic [2:0] op);
    return op > OP_SLL;
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < W; i++) r[i] = d[W-1-i];
    return r;
  endfunction

  // Right-only step of s bits; the fill depends on the op.
  function automatic logic [W-1:0] step(input logic [W-1:0] d, input int unsigned s,
                                        input logic [2:0] op, input logic sign);
    logic [W-1:0] r;
    if (is_rot(op)) begin
      r = (d >> s) | (d << (W - s));
    end else begin
      r = d >> s;
      if ((op == OP_SRA) && sign) r = r | ~({W{1'b1}} >> s);
    end
    return r;
  endfunction

`ifdef BARREL_SHIFTER_STICKY_EN
  // Low s bits fall off a right step; for SLL these are the original high bits.
  function automatic logic discard(input logic [W-1:0] d, input int unsigned s);
    return |(d & ~({W{1'b1}} << s));
  endfunction
`endif

  logic           valid_q [N];
  logic [W-1:0]   data_q  [N];
  logic [2:0]     op_q    [N];
  logic [N-1:0]   amt_q   [N];
  logic           sign_q  [N];
  logic           zero_q;

  logic           valid_d [N];
  logic [W-1:0]   data_d  [N];
  logic [2:0]     op_d    [N];
  logic [N-1:0]   amt_d   [N];
  logic           sign_d  [N];
  logic           zero_d;

  logic [W-1:0]   src_data [N];
  logic [N-1:0]   src_amt  [N];
  logic           ready    [N+1];

`ifdef BARREL_SHIFTER_STICKY_EN
  logic           sticky_q [N];
  logic           sticky_d [N];
  logic           src_sticky [N];
`endif

  always_comb begin
    ready[N] = out_ready;
    for (int unsigned i = N; i > 0; i--) ready[i-1] = !valid_q[i-1] || ready[i];
  end

  always_comb begin
    // Stage inputs: stage 0 from the port, stage k from stage k-1.
    valid_d[0]  = in_valid;
    src_data[0] = is_left(in_op) ? rev(in_data) : in_data;
    src_amt[0]  = is_pass(in_op) ? '0 : in_amt;
    op_d[0]     = in_op;
    sign_d[0]   = in_data[W-1];
`ifdef BARREL_SHIFTER_STICKY_EN
    src_sticky[0] = 1'b0;
`endif
    for (int unsigned k = 1; k < N; k++) begin
      valid_d[k]  = valid_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      op_d[k]     = op_q[k-1];
      sign_d[k]   = sign_q[k-1];
`ifdef BARREL_SHIFTER_STICKY_EN
      src_sticky[k] = sticky_q[k-1];
`endif
    end

    for (int unsigned k = 0; k < N; k++) begin
      amt_d[k]  = src_amt[k];
      data_d[k] = src_amt[k][k] ? step(src_data[k], 32'd1 << k, op_d[k], sign_d[k])
                                : src_data[k];
`ifdef BARREL_SHIFTER_STICKY_EN
      sticky_d[k] = src_sticky[k] |
                    (src_amt[k][k] && !is_rot(op_d[k]) && discard(src_data[k], 32'd1 << k));
`endif
    end

    // Undo the entry reversal for left ops before the result is registered,
    // so out_data and out_zero come straight from flops.
    if (is_left(op_d[N-1])) data_d[N-1] = rev(data_d[N-1]);
    zero_d = (data_d[N-1] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        valid_q[k]  <= 1'b0;
        data_q[k]   <= '0;
        op_q[k]     <= '0;
        amt_q[k]    <= '0;
        sign_q[k]   <= 1'b0;
`ifdef BARREL_SHIFTER_STICKY_EN
        sticky_q[k] <= 1'b0;
`endif
      end
      zero_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (ready[k]) begin
          valid_q[k]  <= valid_d[k];
          data_q[k]   <= data_d[k];
          op_q[k]     <= op_d[k];
          amt_q[k]    <= amt_d[k];
          sign_q[k]   <= sign_d[k];
`ifdef BARREL_SHIFTER_STICKY_EN
          sticky_q[k] <= sticky_d[k];
`endif
        end
      end
      if (ready[N-1]) zero_q <= zero_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];
  assign out_zero  = zero_q;
`ifdef BARREL_SHIFTER_STICKY_EN
  assign out_sticky = sticky_q[N-1];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe: an N=3 instance for directed, latency,
// backpressure and reset scenarios, and an N=5 instance for long random traffic.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // N=3 instance
  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [7:0] a_in_data = '0, a_out_data;
  logic [2:0] a_in_amt = '0, a_in_op = '0;
  logic       a_zero, a_sticky;

  // N=5 instance
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [4:0]  b_in_amt = '0;
  logic [2:0]  b_in_op = '0;
  logic        b_zero, b_sticky;

  logic rnd_b = 1'b0;

  barrel_shifter_pipe #(.N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_amt(a_in_amt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_zero(a_zero), .out_sticky(a_sticky)
  );

  barrel_shifter_pipe #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_amt(b_in_amt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_zero(b_zero), .out_sticky(b_sticky)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        s;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain arithmetic on a w-bit value held in 64 bits.
  function automatic exp_t model(input logic [31:0] din, input int unsigned a,
                                 input logic [2:0] op, input int unsigned w);
    longint unsigned m, d, r;
    logic s;
    exp_t e;
    m = (64'd1 << w) - 64'd1;
    d = longint'(din) & m;
    s = 1'b0;
    case (op)
      3'd0: r = ((d >> a) | (d << (w - a))) & m;
      3'd1: r = ((d << a) | (d >> (w - a))) & m;
      3'd2: begin r = d >> a; s = (d & ((64'd1 << a) - 64'd1)) != 0; end
      3'd3: begin
        r = d >> a;
        if (((d >> (w - 1)) & 64'd1) != 0) r = r | (m & ~(m >> a));
        s = (d & ((64'd1 << a) - 64'd1)) != 0;
      end
      3'd4: begin r = (d << a) & m; s = (d >> (w - a)) != 0; end
      default: r = d;
    endcase
`ifndef BARREL_SHIFTER_STICKY_EN
    s = 1'b0;
`endif
    e.d = r[31:0];
    e.z = (r == 0);
    e.s = s;
    return e;
  endfunction

  exp_t qa[$];
  exp_t qb[$];

  // Handshake values are stable at the falling edge and decide the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) fail_now("a_unexpected_output");
        else begin
          e = qa.pop_front();
          chk("a_data", 64'(a_out_data), 64'(e.d[7:0]));
          chk("a_zero", 64'(a_zero), 64'(e.z));
          chk("a_sticky", 64'(a_sticky), 64'(e.s));
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(model(32'(a_in_data), a_in_amt, a_in_op, 8));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) fail_now("b_unexpected_output");
        else begin
          e = qb.pop_front();
          chk("b_data", 64'(b_out_data), 64'(e.d));
          chk("b_zero", 64'(b_zero), 64'(e.z));
          chk("b_sticky", 64'(b_sticky), 64'(e.s));
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(model(b_in_data, b_in_amt, b_in_op, 32));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_b) b_out_ready = ($urandom_range(0, 3) != 0);
  end

  // Leaves in_valid high; returns 1 time unit after the accepting edge.
  task automatic send_a(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a);
    logic acc;
    acc = 1'b0;
    a_in_op = op; a_in_data = d; a_in_amt = a; a_in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) fail_now("a_accept_timeout");
  endtask

  task automatic send_b(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
    logic acc;
    acc = 1'b0;
    b_in_op = op; b_in_data = d; b_in_amt = a; b_in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) fail_now("b_accept_timeout");
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] d;
    logic [2:0] a;
    logic [7:0] e;
    logic       s;
  } dir_t;

  dir_t dv [9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] snap;
    int unsigned lat, cnt;
    logic found;

    dv[0] = '{op: 3'b000, d: 8'hB1, a: 3'd3, e: 8'h36, s: 1'b0};
    dv[1] = '{op: 3'b001, d: 8'hB1, a: 3'd3, e: 8'h8D, s: 1'b0};
    dv[2] = '{op: 3'b011, d: 8'hB1, a: 3'd2, e: 8'hEC, s: 1'b1};
    dv[3] = '{op: 3'b010, d: 8'h80, a: 3'd7, e: 8'h01, s: 1'b0};
    dv[4] = '{op: 3'b100, d: 8'hB1, a: 3'd1, e: 8'h62, s: 1'b1};
    dv[5] = '{op: 3'b010, d: 8'h01, a: 3'd1, e: 8'h00, s: 1'b1};
    dv[6] = '{op: 3'b110, d: 8'h5A, a: 3'd5, e: 8'h5A, s: 1'b0};
    dv[7] = '{op: 3'b011, d: 8'hB1, a: 3'd0, e: 8'hB1, s: 1'b0};
    dv[8] = '{op: 3'b001, d: 8'hC3, a: 3'd0, e: 8'hC3, s: 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors on an empty pipe; result must show on the third falling
    // edge after the accepting edge t, i.e. right after edge t+N-1.
    foreach (dv[i]) begin
      send_a(dv[i].op, dv[i].d, dv[i].a);
      a_in_valid = 1'b0;
      lat = 0;
      found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
        @(negedge clk);
        lat++;
        found = a_out_valid;
      end
      chk("dir_latency", 64'(lat), 64'd3);
      chk("dir_data", 64'(a_out_data), 64'(dv[i].e));
      chk("dir_zero", 64'(a_zero), 64'(dv[i].e == 8'h00));
`ifdef BARREL_SHIFTER_STICKY_EN
      chk("dir_sticky", 64'(a_sticky), 64'(dv[i].s));
`else
      chk("dir_sticky", 64'(a_sticky), 64'd0);
`endif
      @(posedge clk);
      #1;
    end

    // Backpressure: three fill the pipe, the fourth waits.
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_a(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom));
    a_in_op = 3'($urandom_range(0, 7)); a_in_data = 8'($urandom); a_in_amt = 3'($urandom);
    @(negedge clk);
    chk("bp_in_ready_full", 64'(a_in_ready), 64'd0);
    chk("bp_out_valid", 64'(a_out_valid), 64'd1);
    snap = a_out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(a_out_data), 64'(snap));
      chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    @(negedge clk);
    cnt = 32'(a_out_valid);
    chk("bp_in_ready_reopen", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += 32'(a_out_valid);
    end
    chk("bp_burst_len", 64'(cnt), 64'd4);
    @(posedge clk);
    #1;

    // Reset with a full pipe and a transaction offered during reset.
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_a(3'($urandom_range(0, 7)), 8'($urandom | 1), 3'($urandom));
    a_in_data = 8'hFF;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst2_out_data", 64'(a_out_data), 64'd0);
    chk("rst2_out_zero", 64'(a_zero), 64'd0);
    chk("rst2_out_sticky", 64'(a_sticky), 64'd0);
    chk("rst2_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_a(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom));
    a_in_valid = 1'b0;

    // Long random traffic on the N=5 instance with random downstream stalls.
    rnd_b = 1'b1;
    for (int i = 0; i < 1000; i++)
      send_b(3'($urandom_range(0, 7)), $urandom, 5'($urandom));
    b_in_valid = 1'b0;
    rnd_b = 1'b0;
    @(posedge clk);
    #1 b_out_ready = 1'b1;
    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_b", 64'(qb.size()), 64'd0);
    chk("idle_a_valid", 64'(a_out_valid), 64'd0);
    chk("idle_b_valid", 64'(b_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
